// File: rtl/frame_checker_pkg.sv
// Shared constants and types for the speed-tester frame checker; the
// generator uses the same header layout and magic.
package frame_checker_pkg;

    localparam logic [31:0] TEST_MAGIC    = 32'h4C4E4154;  // "TANL"
    localparam int          MAGIC_OFFSET  = 14;
    localparam int          SEQ_OFFSET    = 18;
    localparam int          MIN_HDR_BYTES = 22;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [63:0] frames;
        logic [63:0] bytes;
        logic [31:0] seq_err;
        logic [31:0] bad;
    } port_stats_t;

    // Completed-frame record handed from the frame tracker to the counters.
    typedef struct packed {
        logic        vld;
        logic        bad;
        logic [15:0] bytes;
        logic [31:0] seq;
    } frame_upd_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/keep_popcount.sv
// Combinational population count of an AXIS keep vector.
module keep_popcount #(
    parameter int WIDTH = 64,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] keep,
    output logic [CW-1:0]    count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CW'(keep[i]);
        end
    end

endmodule

// File: rtl/frame_checker.sv
// Receive-side frame checker: validates magic and sequence numbers of
// looped-back test frames and keeps per-port counters for host readout.
module frame_checker
    import frame_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    input  logic                    start,
    input  logic                    stop,
    input  logic [DATA_WIDTH-1:0]   axis_s_data,
    input  logic [DATA_WIDTH/8-1:0] axis_s_keep,
    input  logic                    axis_s_last,
    input  logic [DATA_WIDTH/8-1:0] axis_s_user,
    input  logic [ID_WIDTH-1:0]     axis_s_id,
    input  logic                    axis_s_valid,
    output logic                    axis_s_ready,
    input  logic [ID_WIDTH-1:0]     stat_sel,
    output logic [63:0]             stat_frames,
    output logic [63:0]             stat_bytes,
    output logic [31:0]             stat_seq_err,
    output logic [31:0]             stat_bad
);

    localparam int KW     = DATA_WIDTH / 8;
    localparam int CW     = $clog2(KW + 1);
    localparam int NPORTS = 2 ** ID_WIDTH;

    state_e              state_q, state_d;
    logic                axis_ready_q, axis_ready_d;
    logic                in_frame_q, in_frame_d;
    logic                count_en_q, count_en_d;
    logic                frame_bad_q, frame_bad_d;
    logic [15:0]         byte_acc_q, byte_acc_d;
    logic [31:0]         seq_q, seq_d;
    frame_upd_t          upd_q, upd_d;
    logic [ID_WIDTH-1:0] upd_id_q, upd_id_d;
    port_stats_t         stats_q [NPORTS];
    port_stats_t         stats_d [NPORTS];
    logic [31:0]         exp_q [NPORTS];
    logic [31:0]         exp_d [NPORTS];
    logic [NPORTS-1:0]   seq_valid_q, seq_valid_d;
    port_stats_t         stat_q, stat_d;

    logic [CW-1:0]       beat_bytes;
    logic                hs, first, last_hs, hdr_bad, beat_err, clear;
    logic [31:0]         hdr_magic, hdr_seq;
    logic [15:0]         acc_base;
    logic [16:0]         acc_sum;

    keep_popcount #(.WIDTH(KW), .CW(CW)) u_keep_popcount (
        .keep  (axis_s_keep),
        .count (beat_bytes)
    );

    // Per-beat frame tracking; header fields only matter on the first beat.
    always_comb begin
        hs        = axis_s_valid & axis_ready_q;
        first     = hs & ~in_frame_q;
        last_hs   = hs & axis_s_last;
        hdr_magic = axis_s_data[MAGIC_OFFSET*8 +: 32];
        hdr_seq   = axis_s_data[SEQ_OFFSET*8 +: 32];
        hdr_bad   = (hdr_magic != TEST_MAGIC) || (beat_bytes < CW'(MIN_HDR_BYTES));
        beat_err  = |(axis_s_user & axis_s_keep);
        acc_base  = first ? 16'd0 : byte_acc_q;
        acc_sum   = {1'b0, acc_base} + 17'(beat_bytes);

        in_frame_d  = in_frame_q;
        count_en_d  = count_en_q;
        frame_bad_d = frame_bad_q;
        byte_acc_d  = byte_acc_q;
        seq_d       = seq_q;
        if (hs) begin
            in_frame_d = ~axis_s_last;
            byte_acc_d = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
            if (first) begin
                count_en_d  = (state_q == RUN);
                frame_bad_d = hdr_bad | beat_err;
                seq_d       = hdr_seq;
            end else begin
                frame_bad_d = frame_bad_q | beat_err;
            end
        end

        upd_d.vld   = last_hs & count_en_d;
        upd_d.bad   = frame_bad_d;
        upd_d.bytes = byte_acc_d;
        upd_d.seq   = seq_d;
        upd_id_d    = axis_s_id;
    end

    // A stop with a counted frame still open waits in DRAIN for its last beat.
    always_comb begin
        state_d      = state_q;
        axis_ready_d = 1'b1;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (stop) state_d = (in_frame_d & count_en_d) ? DRAIN : IDLE;
            DRAIN:   if (last_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        clear = (state_q == IDLE) & start;
    end

    // Sequence compare runs in the apply stage against the live expected
    // value, so a back-to-back frame on the same port sees the prior update.
    always_comb begin
        stats_d     = stats_q;
        exp_d       = exp_q;
        seq_valid_d = seq_valid_q;
        if (clear) begin
            for (int p = 0; p < NPORTS; p++) begin
                stats_d[p] = '0;
                exp_d[p]   = '0;
            end
            seq_valid_d = '0;
        end else if (upd_q.vld) begin
            if (upd_q.bad) begin
                stats_d[upd_id_q].bad = sat_inc32(stats_q[upd_id_q].bad);
            end else begin
                stats_d[upd_id_q].frames = stats_q[upd_id_q].frames + 64'd1;
                stats_d[upd_id_q].bytes  = stats_q[upd_id_q].bytes + 64'(upd_q.bytes);
                if (seq_valid_q[upd_id_q] && (upd_q.seq != exp_q[upd_id_q])) begin
                    stats_d[upd_id_q].seq_err = sat_inc32(stats_q[upd_id_q].seq_err);
                end
                exp_d[upd_id_q]       = upd_q.seq + 32'd1;
                seq_valid_d[upd_id_q] = 1'b1;
            end
        end
        stat_d = stats_q[stat_sel];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            axis_ready_q <= 1'b0;
            in_frame_q   <= 1'b0;
            count_en_q   <= 1'b0;
            frame_bad_q  <= 1'b0;
            byte_acc_q   <= '0;
            seq_q        <= '0;
            upd_q        <= '0;
            upd_id_q     <= '0;
            seq_valid_q  <= '0;
            stat_q       <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                stats_q[p] <= '0;
                exp_q[p]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            axis_ready_q <= axis_ready_d;
            in_frame_q   <= in_frame_d;
            count_en_q   <= count_en_d;
            frame_bad_q  <= frame_bad_d;
            byte_acc_q   <= byte_acc_d;
            seq_q        <= seq_d;
            upd_q        <= upd_d;
            upd_id_q     <= upd_id_d;
            seq_valid_q  <= seq_valid_d;
            stat_q       <= stat_d;
            for (int p = 0; p < NPORTS; p++) begin
                stats_q[p] <= stats_d[p];
                exp_q[p]   <= exp_d[p];
            end
        end
    end

    assign ready        = (state_q == IDLE);
    assign axis_s_ready = axis_ready_q;
    assign stat_frames  = stat_q.frames;
    assign stat_bytes   = stat_q.bytes;
    assign stat_seq_err = stat_q.seq_err;
    assign stat_bad     = stat_q.bad;

endmodule

// File: tb/tb_frame_checker.sv
// Scoreboard bench for frame_checker: directed frames, expected counter
// readouts queued by the driver and compared by an independent monitor.
module tb_frame_checker;

    localparam logic [31:0] MAGIC = 32'h4C4E4154;

    logic         clk = 1'b0;
    logic         rst;
    logic         ready;
    logic         start, stop;
    logic [511:0] axis_s_data;
    logic [63:0]  axis_s_keep, axis_s_user;
    logic         axis_s_last, axis_s_valid, axis_s_ready;
    logic [2:0]   axis_s_id, stat_sel;
    logic [63:0]  stat_frames, stat_bytes;
    logic [31:0]  stat_seq_err, stat_bad;

    frame_checker dut (
        .clk          (clk),
        .rst          (rst),
        .ready        (ready),
        .start        (start),
        .stop         (stop),
        .axis_s_data  (axis_s_data),
        .axis_s_keep  (axis_s_keep),
        .axis_s_last  (axis_s_last),
        .axis_s_user  (axis_s_user),
        .axis_s_id    (axis_s_id),
        .axis_s_valid (axis_s_valid),
        .axis_s_ready (axis_s_ready),
        .stat_sel     (stat_sel),
        .stat_frames  (stat_frames),
        .stat_bytes   (stat_bytes),
        .stat_seq_err (stat_seq_err),
        .stat_bad     (stat_bad)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          chk_st;
        logic [63:0] f, b, se, bd;
        bit          chk_rdy;
        logic        rdy, axr;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic rd_req = 1'b0;
    logic rd_pend = 1'b0;
    bit   fin_req = 1'b0;
    bit   fin_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Monitor: one queued expectation per read pulse, checked after the edge.
    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin
        exp_t e;
        if (rd_pend) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_underflow: read with no expectation queued");
            end else begin
                e = sb.pop_front();
                if (e.chk_st) begin
                    chk({e.tag, ".frames"},  stat_frames,       e.f);
                    chk({e.tag, ".bytes"},   stat_bytes,        e.b);
                    chk({e.tag, ".seq_err"}, 64'(stat_seq_err), e.se);
                    chk({e.tag, ".bad"},     64'(stat_bad),     e.bd);
                end
                if (e.chk_rdy) begin
                    chk({e.tag, ".ready"},        64'(ready),        64'(e.rdy));
                    chk({e.tag, ".axis_s_ready"}, 64'(axis_s_ready), 64'(e.axr));
                end
            end
        end else if (fin_req && !fin_done) begin
            fin_done = 1'b1;
            chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        end
    end

    function automatic logic [511:0] hdr(input logic [31:0] magic, input logic [31:0] seq);
        logic [511:0] d;
        for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(i + 8'h40);
        d[14*8 +: 32] = magic;
        d[18*8 +: 32] = seq;
        return d;
    endfunction

    function automatic logic [63:0] km(input int n);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
    endtask

    task automatic push(input string tag, input bit chk_st, input logic [63:0] f, input logic [63:0] b,
                        input logic [63:0] se, input logic [63:0] bd, input bit chk_rdy,
                        input logic rdy, input logic axr);
        exp_t e;
        e.tag = tag; e.chk_st = chk_st; e.f = f; e.b = b; e.se = se; e.bd = bd;
        e.chk_rdy = chk_rdy; e.rdy = rdy; e.axr = axr;
        sb.push_back(e);
        rd_req = 1'b1;
    endtask

    task automatic rd(input string tag, input int id, input logic [63:0] f, input logic [63:0] b,
                      input logic [63:0] se, input logic [63:0] bd);
        stat_sel = 3'(id);
        push(tag, 1'b1, f, b, se, bd, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic expect_rdy(input string tag, input logic rdy);
        push(tag, 1'b0, 0, 0, 0, 0, 1'b1, rdy, 1'b1);
    endtask

    task automatic beat(input int id, input logic [511:0] d, input logic [63:0] k,
                        input logic [63:0] u, input logic last);
        axis_s_id    = 3'(id);
        axis_s_data  = d;
        axis_s_keep  = k;
        axis_s_user  = u;
        axis_s_last  = last;
        axis_s_valid = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        axis_s_valid = 1'b0;
        axis_s_last  = 1'b0;
        axis_s_user  = '0;
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] full;
        full = km(64);
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        axis_s_data = '0; axis_s_keep = '0; axis_s_user = '0; axis_s_last = 1'b0;
        axis_s_id = '0; axis_s_valid = 1'b0; stat_sel = '0;
        repeat (3) tick();

        // Reset state, sampled while reset is held.
        stat_sel = 3'd2;
        push("reset", 1'b1, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        expect_rdy("post_reset", 1'b1);
        tick();
        pulse_start();

        // Port 2: ten in-order 64-byte frames.
        for (int i = 0; i < 10; i++) beat(2, hdr(MAGIC, 32'(100 + i)), full, '0, 1'b1);
        idle(2);
        for (int p = 0; p < 8; p++) begin
            if (p == 2) rd("p2_run", p, 10, 640, 0, 0);
            else        rd($sformatf("p%0d_zero", p), p, 0, 0, 0, 0);
        end

        // Port 0: gap then duplicate.
        beat(0, hdr(MAGIC, 5), full, '0, 1'b1);
        beat(0, hdr(MAGIC, 6), full, '0, 1'b1);
        beat(0, hdr(MAGIC, 8), full, '0, 1'b1);
        beat(0, hdr(MAGIC, 9), full, '0, 1'b1);
        idle(2);
        rd("p0_gap", 0, 4, 256, 1, 0);
        beat(0, hdr(MAGIC, 9), full, '0, 1'b1);
        idle(2);
        rd("p0_dup", 0, 5, 320, 2, 0);
        beat(0, hdr(MAGIC, 10), full, '0, 1'b1);
        idle(2);
        rd("p0_resync", 0, 6, 384, 2, 0);

        // Port 1: MAC error on beat 2 of a 150-byte frame, then baseline.
        beat(1, hdr(MAGIC, 49), full, '0, 1'b0);
        beat(1, hdr(32'h0, 32'h0), full, 64'h8, 1'b0);
        beat(1, hdr(32'h0, 32'h0), km(22), '0, 1'b1);
        idle(2);
        rd("p1_user_err", 1, 0, 0, 0, 1);
        beat(1, hdr(MAGIC, 50), full, '0, 1'b1);
        idle(2);
        rd("p1_baseline", 1, 1, 64, 0, 1);

        // Port 4: bad magic, 20-byte runt, then 22-byte minimum good frame.
        beat(4, hdr(32'hDEADBEEF, 0), full, '0, 1'b1);
        beat(4, hdr(MAGIC, 0), km(20), '0, 1'b1);
        idle(2);
        rd("p4_bad", 4, 0, 0, 0, 2);
        beat(4, hdr(MAGIC, 7), km(22), '0, 1'b1);
        idle(2);
        rd("p4_min_len", 4, 1, 22, 0, 2);

        // Port 5: stop on beat 1 of a 4-beat frame drains it.
        stop = 1'b1;
        expect_rdy("drain_b1", 1'b0);
        beat(5, hdr(MAGIC, 0), full, '0, 1'b0);
        expect_rdy("drain_b2", 1'b0);
        beat(5, hdr(32'h0, 32'h0), full, '0, 1'b0);
        expect_rdy("drain_b3", 1'b0);
        beat(5, hdr(32'h0, 32'h0), full, '0, 1'b0);
        expect_rdy("drain_last", 1'b1);
        beat(5, hdr(32'h0, 32'h0), full, '0, 1'b1);
        idle(2);
        rd("p5_drained", 5, 1, 256, 0, 0);
        expect_rdy("idle_frame", 1'b1);
        beat(5, hdr(MAGIC, 1), full, '0, 1'b1);
        idle(2);
        rd("p5_idle_ignored", 5, 1, 256, 0, 0);

        // Port 3: 1000 back-to-back single-beat frames.
        pulse_start();
        for (int i = 0; i < 1000; i++) beat(3, hdr(MAGIC, 32'(i)), full, '0, 1'b1);
        idle(2);
        rd("p3_b2b", 3, 1000, 64000, 0, 0);
        rd("p5_cleared", 5, 0, 0, 0, 0);
        rd("p0_cleared", 0, 0, 0, 0, 0);

        // Restart clears counters.
        stop = 1'b1;
        tick();
        pulse_start();
        idle(1);
        rd("p3_restart", 3, 0, 0, 0, 0);

        // Reset in the middle of a frame.
        beat(3, hdr(MAGIC, 0), full, '0, 1'b1);
        beat(3, hdr(MAGIC, 1), full, '0, 1'b1);
        idle(2);
        rd("p3_pre_rst", 3, 2, 128, 0, 0);
        beat(3, hdr(MAGIC, 2), full, '0, 1'b0);
        axis_s_valid = 1'b0;
        rst = 1'b0;
        stat_sel = 3'd3;
        push("mid_rst", 1'b1, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        pulse_start();
        beat(3, hdr(MAGIC, 3), full, '0, 1'b1);
        idle(2);
        rd("p3_post_rst", 3, 1, 64, 0, 0);

        idle(3);
        fin_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_checker.md
Name: frame_checker

Overview:
- Receive-side counterpart of the frame generator in the speed tester.
- Sinks an AXI-Stream of test frames looped back from the device under test, demultiplexed by port (axis_s_id).
- Validates each frame's magic word and sequence number, and keeps per-port counters for frames, bytes, sequence errors and bad frames.
- A select/readout port exposes the counters to the host-control logic.

Parameters:
DATA_WIDTH, 512, AXIS data width in bits (multiple of 64)
ID_WIDTH, 3, port id width; NPORTS = 2**ID_WIDTH counter sets

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
ready  output  1  high in IDLE: checker stopped, may be started
start  input  1  single-cycle pulse: clear all counters, enter RUN
stop  input  1  single-cycle pulse: finish current frame, return to IDLE
axis_s_data  input  DATA_WIDTH  frame data, byte 0 at bits [7:0]
axis_s_keep  input  DATA_WIDTH/8  byte enables; contiguous from bit 0
axis_s_last  input  1  last beat of frame
axis_s_user  input  DATA_WIDTH/8  per-byte error flag from MAC; any set bit marks the frame bad
axis_s_id  input  ID_WIDTH  port id; constant within a frame
axis_s_valid  input  1  beat valid
axis_s_ready  output  1  beat accepted
stat_sel  input  ID_WIDTH  port whose counters are read
stat_frames  output  64  good frames on stat_sel
stat_bytes  output  64  bytes in good frames (sum of keep bits)
stat_seq_err  output  32  sequence errors on stat_sel
stat_bad  output  32  bad frames on stat_sel

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE; ready=1; axis_s_ready=0.
  - All counters, expected-sequence valid bits and stat_* are 0.
  - Reset mid-frame discards that frame.
- axis_s_ready=1 in every cycle after reset, in both states. The checker never back-pressures; frames arriving in IDLE are consumed and not counted.
- FSM states IDLE, RUN, DRAIN:
  - IDLE + start -> RUN. Same cycle: clear every counter and every seq_valid bit.
  - RUN + stop -> DRAIN if a counted frame is open, otherwise IDLE.
  - DRAIN -> IDLE on the handshake of that frame's last beat.
  - start outside IDLE is ignored; stop outside RUN is ignored; start and stop together in IDLE -> start wins.
  - ready = (state==IDLE).
- Frame tracking:
  - in_frame is set by the first handshake (valid&ready) and cleared by the last-beat handshake.
  - count_en is latched on the first beat = (state==RUN). A frame already in flight at start is not counted. A frame open at stop is counted fully.
  - frame_bad accumulates OR(axis_s_user & axis_s_keep) over all beats.
  - byte_acc accumulates popcount(axis_s_keep) per beat, 16-bit saturating.
- Header, first beat only, byte offsets:
  - Magic at bytes 14..17, little-endian 32-bit value, must equal 0x4C4E4154 ("TANL").
  - Sequence number at bytes 18..21, little-endian 32-bit.
  - The frame is bad if the magic mismatches, or if popcount(keep) < 22 on the first beat. A single-beat frame shorter than 22 bytes is therefore bad.
- On last beat, if count_en (registered into a 1-stage update pipeline):
  - Bad frame: bad[id]+=1. No sequence check, expected sequence unchanged.
  - Good frame: frames[id]+=1 and bytes[id]+=byte_acc.
    - If seq_valid[id] and seq != exp[id], then seq_err[id]+=1.
    - In all good cases: exp[id]=seq+1 (mod 2^32) and seq_valid[id]=1.
    - The first good frame per port after start only establishes the baseline.
- Latency and arithmetic:
  - Counters reflect a frame 2 cycles after its last-beat handshake.
  - Back-to-back single-beat frames on the same port every cycle must all be counted; forward the pending update.
  - frames and bytes wrap modulo 2^64; seq_err and bad saturate at 0xFFFFFFFF.
- Readout: stat_* is registered, showing the counters of stat_sel sampled 1 cycle earlier.

Decomposition:
- Package frame_checker_pkg holds:
  - TEST_MAGIC=32'h4C4E4154, MAGIC_OFFSET=14, SEQ_OFFSET=18, MIN_HDR_BYTES=22.
  - State enum {IDLE, RUN, DRAIN}.
  - Struct port_stats_t {frames, bytes, seq_err, bad}.
  - The generator shares these constants.
- One sub-module: keep_popcount (DATA_WIDTH/8-bit popcount, combinational, 7-bit result for the default width).

Test Plan:
- Reset, then start. Port 2: 10 frames of 64 bytes (1 beat each), seq 100..109, magic OK -> port 2 reads frames=10, bytes=640, seq_err=0, bad=0; other ports all 0.
- Port 0: seq 5,6,8,9 -> seq_err=1 and frames=4. Then seq 9 again -> seq_err=2 (duplicate); exp becomes 10.
- Port 1: 3-beat 150-byte frame with axis_s_user bit 3 set on beat 2 -> bad=1, frames=0, bytes=0; next good frame seq 50 -> frames=1, seq_err=0.
- Frame with magic 0xDEADBEEF, and a 20-byte frame with good magic -> bad=2 on that port; frames unchanged.
- Stop asserted on beat 1 of a 4-beat 256-byte frame: ready=0 until the last-beat handshake, 1 the next cycle; frame counted (bytes+=256). A following frame in IDLE changes nothing, and axis_s_ready stays 1.
- Back-to-back 1-beat 64-byte frames on port 3 for 1000 cycles -> frames=1000, bytes=64000. Then start again -> all counters read 0. rst low mid-frame -> ready=1 and all stats 0 next cycle.
